bytecode_assembler: RTL and testbench

Consumer end of the bytecode fetch stream. Accepts one bytecode byte per handshake from `fetch`, plus its PC. Groups each opcode with its 0–2 inline operand bytes and presents one complete instruction per output handshake to decode/execute. Owns the operand-length table and flags opcodes the core does not support.

---
 rtl/bytecode_assembler.sv | 182 ++++++++++++++++++
 tb/tb_bytecode_assembler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bytecode_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : bytecode_assembler
//  Description : Groups a bytecode byte stream into whole instructions
//                (opcode + 0..2 big-endian operand bytes) and flags
//                opcodes the core does not implement.
//  Revision    : 1.0 - initial release
// ============================================================================
module bytecode_assembler #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [7:0]      in_byte,
    input  logic [PC_W-1:0] in_pc,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [7:0]      out_opcode,
    output logic [15:0]     out_operand,
    output logic [1:0]      out_len,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
);

    typedef enum logic [1:0] {
        ST_OPC = 2'd0,
        ST_OP1 = 2'd1,
        ST_OP2 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_two_left;     // current instruction carries two operand bytes
    logic [7:0]      r_opc;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_b1;

    logic            w_accept;
    logic [1:0]      w_dec_len;
    logic            w_dec_illegal;

    logic            w_done;
    logic [7:0]      w_done_opcode;
    logic [15:0]     w_done_operand;
    logic [1:0]      w_done_len;
    logic [PC_W-1:0] w_done_pc;
    logic            w_done_illegal;

    // A byte may only enter when the output register is free or draining now;
    // flush blocks the byte presented in its own cycle.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Operand-length table, indexed by the incoming byte as an opcode.
    always_comb begin
        w_dec_len     = 2'd0;
        w_dec_illegal = 1'b0;
        case (in_byte)
            8'h10, 8'h12,
            8'h15, 8'h16, 8'h17, 8'h18, 8'h19,
            8'h36, 8'h37, 8'h38, 8'h39, 8'h3A,
            8'hA9, 8'hBC:
                w_dec_len = 2'd1;
            8'h11, 8'h13, 8'h14, 8'h84,
            8'h99, 8'h9A, 8'h9B, 8'h9C, 8'h9D, 8'h9E, 8'h9F, 8'hA0,
            8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8,
            8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8,
            8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7:
                w_dec_len = 2'd2;
            8'hAA, 8'hAB, 8'hB9, 8'hBA, 8'hC4, 8'hC5, 8'hC8, 8'hC9:
                w_dec_illegal = 1'b1;
            default: ;
        endcase
    end

    // Next state and the instruction completed by this cycle's byte, if any.
    always_comb begin
        w_state_nxt    = r_state;
        w_done         = 1'b0;
        w_done_opcode  = r_opc;
        w_done_operand = 16'h0000;
        w_done_len     = 2'd0;
        w_done_pc      = r_pc;
        w_done_illegal = 1'b0;
        case (r_state)
            ST_OPC: begin
                if (w_accept) begin
                    w_done_opcode = in_byte;
                    w_done_pc     = in_pc;
                    if (w_dec_illegal) begin
                        w_done         = 1'b1;
                        w_done_illegal = 1'b1;
                    end else if (w_dec_len == 2'd0) begin
                        w_done = 1'b1;
                    end else begin
                        w_state_nxt = ST_OP1;
                    end
                end
            end
            ST_OP1: begin
                if (w_accept) begin
                    if (r_two_left) begin
                        w_state_nxt = ST_OP2;
                    end else begin
                        w_done         = 1'b1;
                        w_done_operand = {8'h00, in_byte};
                        w_done_len     = 2'd1;
                        w_state_nxt    = ST_OPC;
                    end
                end
            end
            ST_OP2: begin
                if (w_accept) begin
                    w_done         = 1'b1;
                    w_done_operand = {r_b1, in_byte};
                    w_done_len     = 2'd2;
                    w_state_nxt    = ST_OPC;
                end
            end
            default: w_state_nxt = ST_OPC;
        endcase
        if (flush) begin
            w_state_nxt = ST_OPC;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OPC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Partial-instruction registers: opcode/PC on the opcode byte, b1 in OP1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opc      <= 8'h00;
            r_pc       <= '0;
            r_two_left <= 1'b0;
            r_b1       <= 8'h00;
        end else if (w_accept) begin
            if (r_state == ST_OPC) begin
                r_opc      <= in_byte;
                r_pc       <= in_pc;
                r_two_left <= (w_dec_len == 2'd2);
                r_b1       <= 8'h00;
            end else if (r_state == ST_OP1) begin
                r_b1 <= in_byte;
            end
        end
    end

    // Output register: flush wins, then a completed instruction, then drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= 8'h00;
            out_operand <= 16'h0000;
            out_len     <= 2'd0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_done) begin
            out_valid   <= 1'b1;
            out_opcode  <= w_done_opcode;
            out_operand <= w_done_operand;
            out_len     <= w_done_len;
            out_pc      <= w_done_pc;
            out_illegal <= w_done_illegal;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bytecode_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bytecode_assembler
//  Description : Self-checking bench for bytecode_assembler: a byte-queue
//                reference model compared every cycle, plus directed
//                literal expectations on the emitted instruction log.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bytecode_assembler;

    localparam int PC_W = 12;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic [7:0]      in_byte;
    logic [PC_W-1:0] in_pc;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_opcode;
    logic [15:0]     out_operand;
    logic [1:0]      out_len;
    logic [PC_W-1:0] out_pc;
    logic            out_illegal;

    int tests = 0;
    int fails = 0;

    bytecode_assembler #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_pc       (in_pc),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_operand (out_operand),
        .out_len     (out_len),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Operand count of an opcode; 3 marks an unsupported opcode.
    function automatic int len_of(input logic [7:0] op);
        if (op inside {8'hAA, 8'hAB, 8'hB9, 8'hBA, 8'hC4, 8'hC5, 8'hC8, 8'hC9})
            return 3;
        if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3A], 8'hA9, 8'hBC})
            return 1;
        if (op inside {8'h11, 8'h13, 8'h14, 8'h84, [8'h99:8'hA8], [8'hB2:8'hB8],
                       8'hBB, 8'hBD, 8'hC0, 8'hC1, 8'hC6, 8'hC7})
            return 2;
        return 0;
    endfunction

    logic [7:0]      mbuf[$];
    logic [PC_W-1:0] m_pc;
    logic            m_valid;
    logic [7:0]      m_opcode;
    logic [15:0]     m_operand;
    logic [1:0]      m_len;
    logic [PC_W-1:0] m_opc_pc;
    logic            m_illegal;

    // Model advances on each clock edge from the inputs present at that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mbuf.delete();
            m_valid   = 1'b0;
            m_opcode  = 8'h00;
            m_operand = 16'h0000;
            m_len     = 2'd0;
            m_opc_pc  = '0;
            m_illegal = 1'b0;
        end else if (flush) begin
            mbuf.delete();
            m_valid = 1'b0;
        end else begin
            logic acc;
            acc = in_valid && (!m_valid || out_ready);
            if (m_valid && out_ready) m_valid = 1'b0;
            if (acc) begin
                int l;
                int need;
                if (mbuf.size() == 0) m_pc = in_pc;
                mbuf.push_back(in_byte);
                l    = len_of(mbuf[0]);
                need = (l == 3) ? 0 : l;
                if (mbuf.size() == need + 1) begin
                    m_valid   = 1'b1;
                    m_opcode  = mbuf[0];
                    m_opc_pc  = m_pc;
                    m_illegal = (l == 3);
                    m_len     = 2'(need);
                    m_operand = (need == 1) ? {8'h00, mbuf[1]} :
                                (need == 2) ? {mbuf[1], mbuf[2]} : 16'h0000;
                    mbuf.delete();
                end
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, !flush && (!m_valid || out_ready));
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("out_opcode", out_opcode, m_opcode);
                check("out_operand", out_operand, m_operand);
                check("out_len", out_len, m_len);
                check("out_pc", out_pc, m_opc_pc);
                check("out_illegal", out_illegal, m_illegal);
            end
        end
    end

    // Log of delivered instructions {opcode, operand, len, pc, illegal}.
    logic [38:0] obs[$];
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush)
            obs.push_back({out_opcode, out_operand, out_len, out_pc, out_illegal});
    end

    task automatic check_obs(input int idx, input logic [7:0] op, input logic [15:0] opnd,
                             input logic [1:0] len, input logic [PC_W-1:0] pc, input logic ill);
        if (idx >= obs.size()) begin
            check("obs_present", 64'(obs.size()), 64'(idx + 1));
        end else begin
            logic [38:0] e;
            e = {op, opnd, len, pc, ill};
            check("obs_instr", obs[idx], e);
        end
    endtask

    // ---------------- driver ----------------
    // All driving happens 1 time unit after a rising edge.
    task automatic send(input logic [7:0] b, input logic [PC_W-1:0] pc);
        logic ok;
        int   n;
        in_valid = 1'b1;
        in_byte  = b;
        in_pc    = pc;
        n        = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 50);
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset values.
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_opcode", out_opcode, 8'h00);
        check("rst_operand", out_operand, 16'h0000);
        check("rst_len", out_len, 2'd0);
        check("rst_pc", out_pc, 12'h000);
        check("rst_illegal", out_illegal, 1'b0);

        // Reset in the middle of a two-operand instruction.
        send(8'h11, 12'd0);
        send(8'h22, 12'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        obs.delete();
        send(8'h60, 12'd7);
        check("rst_mid_valid", out_valid, 1'b1);
        check("rst_mid_opcode", out_opcode, 8'h60);
        idle(2);
        check("rst_mid_count", 64'(obs.size()), 64'd1);
        check_obs(0, 8'h60, 16'h0000, 2'd0, 12'd7, 1'b0);

        // Mixed stream.
        obs.delete();
        send(8'h10, 12'd0); send(8'h05, 12'd1);
        send(8'h11, 12'd2); send(8'h12, 12'd3); send(8'h34, 12'd4);
        send(8'h84, 12'd5); send(8'h01, 12'd6); send(8'hFF, 12'd7);
        idle(2);
        check("mixed_count", 64'(obs.size()), 64'd3);
        check_obs(0, 8'h10, 16'h0005, 2'd1, 12'd0, 1'b0);
        check_obs(1, 8'h11, 16'h1234, 2'd2, 12'd2, 1'b0);
        check_obs(2, 8'h84, 16'h01FF, 2'd2, 12'd5, 1'b0);

        // Backpressure.
        obs.delete();
        out_ready = 1'b0;
        send(8'h00, 12'd10);
        in_valid = 1'b1; in_byte = 8'hA7; in_pc = 12'd11;
        idle(3);
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_hold_opcode", out_opcode, 8'h00);
        check("bp_hold_pc", out_pc, 12'd10);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_byte = 8'h00; in_pc = 12'd12;
        @(posedge clk); #1;
        in_byte = 8'h04; in_pc = 12'd13;
        check("bp_gap_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_goto_valid", out_valid, 1'b1);
        check("bp_goto_opcode", out_opcode, 8'hA7);
        check("bp_goto_operand", out_operand, 16'h0004);
        idle(2);
        check_obs(0, 8'h00, 16'h0000, 2'd0, 12'd10, 1'b0);
        check_obs(1, 8'hA7, 16'h0004, 2'd2, 12'd11, 1'b0);

        // Unsupported opcode.
        obs.delete();
        send(8'hAA, 12'd3);
        send(8'h00, 12'd4);
        idle(2);
        check_obs(0, 8'hAA, 16'h0000, 2'd0, 12'd3, 1'b1);
        check_obs(1, 8'h00, 16'h0000, 2'd0, 12'd4, 1'b0);

        // Flush mid-instruction.
        obs.delete();
        send(8'hB6, 12'd20);
        send(8'h00, 12'd21);
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'h99; in_pc = 12'd22;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        send(8'h03, 12'd23);
        idle(2);
        check("flush_count", 64'(obs.size()), 64'd1);
        check_obs(0, 8'h03, 16'h0000, 2'd0, 12'd23, 1'b0);

        // Idle gaps inside an instruction.
        obs.delete();
        send(8'h11, 12'd30);
        idle(3);
        send(8'hAB, 12'd31);
        idle(2);
        send(8'hCD, 12'd32);
        idle(2);
        check("gap_count", 64'(obs.size()), 64'd1);
        check_obs(0, 8'h11, 16'hABCD, 2'd2, 12'd30, 1'b0);

        // PC wrap and a back-to-back single-byte stream.
        obs.delete();
        send(8'h10, 12'hFFF);
        send(8'h7F, 12'h000);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_byte = 8'(8'h01 + i);
            in_pc   = 12'(12'd1 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        idle(2);
        check("stream_count", 64'(obs.size()), 64'd5);
        check_obs(0, 8'h10, 16'h007F, 2'd1, 12'hFFF, 1'b0);
        check_obs(4, 8'h04, 16'h0000, 2'd0, 12'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
